// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The word-to-address helper matches the shift used by the instruction RAM.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_SHIFT     = 2;

    function automatic logic [31:0] word_to_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << WORD_SHIFT);
    endfunction

endpackage

// File: rtl/imem_loader_byte_to_word_asm.sv
// Little-endian byte-to-word assembler. word_valid_o pulses combinationally with
// the fourth accepted byte so the controller can act on that same transfer.
module byte_to_word_asm
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic [7:0]  byte_i,
    input  logic        xfer_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] buf_q, buf_d;

    // Byte counter and lower-byte buffer next state
    always_comb begin
        cnt_d = cnt_q;
        buf_d = buf_q;
        if (clear_i) begin
            cnt_d = 2'd0;
            buf_d = 24'd0;
        end else if (xfer_i) begin
            case (cnt_q)
                2'd0:    buf_d[7:0]   = byte_i;
                2'd1:    buf_d[15:8]  = byte_i;
                2'd2:    buf_d[23:16] = byte_i;
                default: buf_d        = buf_q;
            endcase
            cnt_d = cnt_q + 2'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Assembler state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            buf_q <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

    assign word_o       = {byte_i, buf_q};
    assign word_valid_o = xfer_i && !clear_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction RAM writer: header count, N words, checksum trailer.
// Holds the CPU in reset until an image with a matching checksum is loaded.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [7:0]  byte_data_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic [31:0] addr_imem_ram_o,
    output logic [31:0] wr_instr_imem_ram_o,
    output logic        wr_en_imem_ram_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        cpu_rst_n_o
);

    localparam int IDX_W = $clog2(MAX_WORDS) + 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        csum_q, csum_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        instr_q, instr_d;
    logic               wr_en_q, wr_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               cpu_rst_n_q, cpu_rst_n_d;
    logic               xfer_s;
    logic               clear_s;
    logic               word_valid_s;
    logic [31:0]        word_s;

    assign byte_ready_o = (state_q == ST_HDR) || (state_q == ST_LOAD) || (state_q == ST_CSUM);
    assign xfer_s       = byte_valid_i && byte_ready_o;
    assign clear_s      = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));

    byte_to_word_asm u_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (clear_s),
        .byte_i       (byte_data_i),
        .xfer_i       (xfer_s),
        .word_o       (word_s),
        .word_valid_o (word_valid_s)
    );

    // Load sequencer: next state plus next values of every registered output
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        csum_d      = csum_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        wr_en_d     = 1'b0;
        done_d      = done_q;
        err_d       = err_q;
        cpu_rst_n_d = cpu_rst_n_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (clear_s) begin
                    state_d     = ST_HDR;
                    idx_d       = '0;
                    csum_d      = 32'd0;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    cpu_rst_n_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_HDR: begin
                if (word_valid_s) begin
                    cnt_d = word_s[IDX_W-1:0];
                    if (word_s == 32'd0) begin
                        state_d = ST_CSUM;
                    end else if (word_s > 32'(MAX_WORDS)) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_LOAD: begin
                if (word_valid_s) begin
                    instr_d = word_s;
                    csum_d  = csum_q + word_s;
                    addr_d  = word_to_addr(BASE_ADDR, 32'(idx_q));
                    wr_en_d = 1'b1;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_WRITE: begin
                idx_d = idx_q + IDX_W'(1);
                if ((idx_q + IDX_W'(1)) == cnt_q) begin
                    state_d = ST_CSUM;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_CSUM: begin
                if (word_valid_s) begin
                    if (word_s == csum_q) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        cpu_rst_n_d = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_CSUM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_HDR) || (state_d == ST_LOAD) ||
                 (state_d == ST_WRITE) || (state_d == ST_CSUM);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            csum_q      <= 32'd0;
            addr_q      <= 32'd0;
            instr_q     <= 32'd0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            csum_q      <= csum_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            wr_en_q     <= wr_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    assign addr_imem_ram_o     = addr_q;
    assign wr_instr_imem_ram_o = instr_q;
    assign wr_en_imem_ram_o    = wr_en_q;
    assign busy_o              = busy_q;
    assign done_o              = done_q;
    assign err_o               = err_q;
    assign cpu_rst_n_o         = cpu_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: streams images byte by byte
// and checks write strobes, status flags and CPU reset release.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [7:0]  byte_data_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic [31:0] addr_imem_ram_o;
    logic [31:0] wr_instr_imem_ram_o;
    logic        wr_en_imem_ram_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        cpu_rst_n_o;

    int          checks   = 0;
    int          failures = 0;
    int          wr_cnt   = 0;
    int          base;
    int          last_wait;
    int          first_wait;
    logic [31:0] wa [0:31];
    logic [31:0] wd [0:31];

    always #5 clk = ~clk;

    imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(2048)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start_i             (start_i),
        .byte_data_i         (byte_data_i),
        .byte_valid_i        (byte_valid_i),
        .byte_ready_o        (byte_ready_o),
        .addr_imem_ram_o     (addr_imem_ram_o),
        .wr_instr_imem_ram_o (wr_instr_imem_ram_o),
        .wr_en_imem_ram_o    (wr_en_imem_ram_o),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .err_o               (err_o),
        .cpu_rst_n_o         (cpu_rst_n_o)
    );

    // Write-port monitor, sampled shortly after each rising edge
    always @(posedge clk) begin
        #2;
        if (wr_en_imem_ram_o) begin
            if (wr_cnt < 32) begin
                wa[wr_cnt] = addr_imem_ram_o;
                wd[wr_cnt] = wr_instr_imem_ram_o;
            end
            wr_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        byte_valid_i = 1'b0;
        repeat (gap) @(negedge clk);
        byte_data_i  = b;
        byte_valid_i = 1'b1;
        last_wait    = 0;
        while (!byte_ready_o && last_wait < 100) begin
            @(negedge clk);
            last_wait++;
        end
        if (last_wait >= 100) check_eq("ready_timeout", 32'(byte_ready_o), 32'd1);
        @(negedge clk);
        byte_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        send_byte(w[7:0], 0);
        first_wait = last_wait;
        send_byte(w[15:8],  $urandom_range(0, max_gap));
        send_byte(w[23:16], $urandom_range(0, max_gap));
        send_byte(w[31:24], $urandom_range(0, max_gap));
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        start_i      = 1'b0;
        byte_data_i  = 8'h00;
        byte_valid_i = 1'b0;
        #12;
        check_eq("rst_flags", {28'd0, busy_o, done_o, err_o, cpu_rst_n_o}, 32'd0);
        check_eq("rst_wr", {30'd0, wr_en_imem_ram_o, byte_ready_o}, 32'd0);
        check_eq("rst_addr", addr_imem_ram_o, 32'd0);
        check_eq("rst_data", wr_instr_imem_ram_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_ready", 32'(byte_ready_o), 32'd0);

        // Basic two-word load
        base = wr_cnt;
        pulse_start();
        check_eq("hdr_busy", 32'(busy_o), 32'd1);
        check_eq("hdr_ready", 32'(byte_ready_o), 32'd1);
        send_word(32'd2, 0);
        send_word(32'h0000_0013, 0);
        send_word(32'h0010_0093, 0);
        check_eq("write_stall", 32'(first_wait), 32'd1);
        send_word(32'h0010_00A6, 0);
        check_eq("basic_done", {29'd0, done_o, err_o, cpu_rst_n_o}, 32'b101);
        check_eq("basic_busy", 32'(busy_o), 32'd0);
        check_eq("basic_nwr", 32'(wr_cnt - base), 32'd2);
        check_eq("basic_a0", wa[base], 32'h0);
        check_eq("basic_d0", wd[base], 32'h0000_0013);
        check_eq("basic_a1", wa[base+1], 32'h4);
        check_eq("basic_d1", wd[base+1], 32'h0010_0093);

        // Bad checksum, restarted from DONE
        base = wr_cnt;
        pulse_start();
        check_eq("restart_clr", {30'd0, done_o, cpu_rst_n_o}, 32'd0);
        send_word(32'd2, 0);
        send_word(32'h0000_0013, 0);
        send_word(32'h0010_0093, 0);
        send_word(32'h0000_0000, 0);
        check_eq("badcs_flags", {29'd0, done_o, err_o, cpu_rst_n_o}, 32'b010);
        check_eq("badcs_nwr", 32'(wr_cnt - base), 32'd2);

        // Oversize header (2049)
        base = wr_cnt;
        pulse_start();
        check_eq("over_errclr", 32'(err_o), 32'd0);
        send_word(32'h0000_0801, 0);
        check_eq("over_err", {29'd0, err_o, byte_ready_o, busy_o}, 32'b100);
        repeat (3) @(negedge clk);
        check_eq("over_nwr", 32'(wr_cnt - base), 32'd0);

        // Exactly MAX_WORDS is accepted, then aborted by reset
        pulse_start();
        send_word(32'd2048, 0);
        check_eq("max_ok", {29'd0, err_o, byte_ready_o, busy_o}, 32'b011);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-length image
        base = wr_cnt;
        pulse_start();
        send_word(32'd0, 0);
        send_word(32'd0, 0);
        check_eq("zero_flags", {29'd0, done_o, err_o, cpu_rst_n_o}, 32'b101);
        check_eq("zero_nwr", 32'(wr_cnt - base), 32'd0);

        // Bubbles and backpressure
        base = wr_cnt;
        pulse_start();
        send_word(32'd3, 3);
        send_word(32'hDEAD_BEEF, 3);
        send_word(32'h1234_5678, 3);
        check_eq("bub_stall", 32'(first_wait), 32'd1);
        send_word(32'h0BAD_F00D, 3);
        send_word(32'hFC90_0574, 3);
        check_eq("bub_flags", {29'd0, done_o, err_o, cpu_rst_n_o}, 32'b101);
        check_eq("bub_nwr", 32'(wr_cnt - base), 32'd3);
        check_eq("bub_d0", wd[base], 32'hDEAD_BEEF);
        check_eq("bub_d1", wd[base+1], 32'h1234_5678);
        check_eq("bub_a2", wa[base+2], 32'h8);
        check_eq("bub_d2", wd[base+2], 32'h0BAD_F00D);

        // Async reset mid-load, then a fresh one-word load
        base = wr_cnt;
        pulse_start();
        send_word(32'd3, 0);
        send_word(32'h0000_0013, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_flags", {28'd0, busy_o, done_o, err_o, cpu_rst_n_o}, 32'd0);
        check_eq("abort_wr", {30'd0, wr_en_imem_ram_o, byte_ready_o}, 32'd0);
        check_eq("abort_nwr", 32'(wr_cnt - base), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = wr_cnt;
        pulse_start();
        send_word(32'd1, 0);
        send_word(32'h0000_1237, 0);
        send_word(32'h0000_1237, 0);
        check_eq("fresh_flags", {29'd0, done_o, err_o, cpu_rst_n_o}, 32'b101);
        check_eq("fresh_nwr", 32'(wr_cnt - base), 32'd1);
        check_eq("fresh_a0", wa[base], 32'h0);
        check_eq("fresh_d0", wd[base], 32'h0000_1237);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction RAM write port.
- Receives a byte stream over a valid/ready handshake: a 4-byte word-count header, N instruction words, then a 4-byte checksum trailer.
- Writes each word to consecutive word addresses.
- Holds the CPU in reset until a load completes with a matching checksum.
- Sits between the host byte link (e.g. UART receiver) and the instruction memory write port.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-byte aligned.
- MAX_WORDS, 2048, capacity of the instruction RAM in 32-bit words; a header count above this is an error.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- byte_data_i  input  8  stream byte.
- byte_valid_i  input  1  byte_data_i is valid.
- byte_ready_o  output  1  loader accepts the byte this cycle; transfer occurs when valid and ready are both high.
- addr_imem_ram_o  output  32  write byte address, BASE_ADDR + 4*idx.
- wr_instr_imem_ram_o  output  32  assembled instruction word.
- wr_en_imem_ram_o  output  1  one-cycle write strobe.
- busy_o  output  1  load in progress (HDR, LOAD, WRITE or CSUM state).
- done_o  output  1  load finished with checksum OK; sticky until the next start_i.
- err_o  output  1  load failed (count out of range or checksum mismatch); sticky until the next start_i.
- cpu_rst_n_o  output  1  active-low CPU reset; goes high only when done_o is high.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; byte counter, word index, word count and checksum accumulator are all 0.
  - All outputs are 0, including cpu_rst_n_o (CPU held in reset).
- States: IDLE, HDR, LOAD, WRITE, CSUM, DONE, ERR. All outputs are registered, except that byte_ready_o is decoded from state.
- byte_ready_o is 1 only in HDR, LOAD and CSUM.
- Byte assembly: little-endian.
  - The first accepted byte fills bits [7:0], the fourth fills bits [31:24].
  - A 2-bit byte counter wraps 3 -> 0 on each complete word.
- IDLE / DONE / ERR on start_i:
  - Go to HDR; clear done_o and err_o; drive cpu_rst_n_o low.
  - Zero the word index, byte counter and checksum accumulator.
- In HDR, states other than IDLE/DONE/ERR ignore start_i.
- HDR, on the 4th byte, latch count N:
  - N == 0 -> CSUM.
  - N > MAX_WORDS -> ERR.
  - Otherwise -> LOAD.
- LOAD, on the 4th byte accepted:
  - Register the word on wr_instr_imem_ram_o.
  - Add the word to the checksum accumulator (mod 2^32).
  - Go to WRITE.
- WRITE (exactly one cycle):
  - wr_en_imem_ram_o = 1; addr_imem_ram_o = BASE_ADDR + (idx << 2); byte_ready_o = 0.
  - On exit, idx increments.
  - If idx+1 == N, go to CSUM; otherwise go to LOAD.
  - Per-word throughput is therefore 4 byte transfers plus 1 write cycle.
- wr_en_imem_ram_o is 0 in every state except WRITE.
- addr_imem_ram_o and wr_instr_imem_ram_o hold their last values outside WRITE.
- CSUM, on the 4th byte:
  - Compare the received word with the accumulator.
  - Equal -> DONE: done_o = 1 and cpu_rst_n_o = 1 from the next cycle.
  - Mismatch -> ERR: err_o = 1 and cpu_rst_n_o stays 0.
- Checksum of an empty image (N = 0) is 32'h0.
- Bubbles: byte_valid_i low mid-word stalls assembly indefinitely; no timeout.
- byte_valid_i while byte_ready_o is low: the byte is not consumed, and the source must hold it.
- Reset mid-load: abort immediately to IDLE. The RAM keeps any partially written words. No write strobe may be emitted in the cycle rst_n deasserts.
- Address width: idx is clog2(MAX_WORDS)+1 bits wide; addresses do not wrap within a legal load.

Decomposition:
- Shared package:
  - State enum (IDLE, HDR, LOAD, WRITE, CSUM, DONE, ERR).
  - Constants BYTES_PER_WORD = 4 and WORD_SHIFT = 2.
  - The same word-to-address shift is used by the instruction RAM.
- One natural sub-module: byte_to_word_asm.
  - Inputs: byte, valid/ready transfer.
  - Outputs: 32-bit little-endian word plus a one-cycle word_valid pulse.
  - Has its own counter and a clear input.
- The FSM, checksum and address logic stay in imem_loader.

Test Plan:
- Basic load: start_i; stream 02 00 00 00, 13 00 00 00, 93 00 10 00, then checksum A6 00 10 00.
  -> Write 32'h0000_0013 @ 0x0, then 32'h0010_0093 @ 0x4, one strobe each.
  -> done_o = 1, cpu_rst_n_o = 1, err_o = 0.
- Bad checksum: same stream with trailer 00 00 00 00.
  -> Both writes occur; err_o = 1, done_o = 0, cpu_rst_n_o stays 0.
- Oversize header: count 01 08 00 00 (2049).
  -> ERR right after the 4th header byte; no write strobes; byte_ready_o = 0.
- Zero-length image: header 00 00 00 00 then checksum 00 00 00 00.
  -> done_o = 1, no writes.
- Backpressure/bubbles: random byte_valid_i gaps with a byte presented during WRITE.
  -> That byte is not consumed until LOAD; the written word matches the stream; exactly N strobes.
- Async reset mid-LOAD after 1 of 3 words, then restart with start_i:
  -> Outputs go 0 immediately; the fresh load of 1 word writes @ BASE_ADDR and completes with done_o = 1.
